// File: rtl/ex_fp_pkg.sv
// Shared definitions for the pipelined FP execute unit: RS entry field map,
// FP operation encodings and the stage payload layout.
package ex_fp_pkg;

    localparam int RD_LSB   = 0;
    localparam int RD_MSB   = 4;
    localparam int SRC1_RDY = 5;
    localparam int SRC1_LSB = 6;
    localparam int SRC1_MSB = 37;
    localparam int SRC2_RDY = 38;
    localparam int SRC2_LSB = 39;
    localparam int SRC2_MSB = 70;
    localparam int REGWR    = 71;
    localparam int OP_LSB   = 76;
    localparam int OP_MSB   = 80;

    typedef enum logic [4:0] {
        FP_ADD   = 5'd0,
        FP_SUB   = 5'd1,
        FP_MIN   = 5'd2,
        FP_MAX   = 5'd3,
        FP_SGNJ  = 5'd4,
        FP_SGNJN = 5'd5,
        FP_SGNJX = 5'd6,
        FP_MV    = 5'd7
    } fp_op_e;

    localparam logic [2:0]  FP_MODE_S = 3'b000;
    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
    } wb_ctl_t;

    // The valid flag is always the LSB of a flattened stage payload.
    localparam int STAGE_V_BIT = 0;

    function automatic int stage_w(input int xlen, input int rob_w);
        return xlen + $bits(wb_ctl_t) + rob_w + 1;
    endfunction

endpackage

// File: rtl/ex_fp_pipe_arb.sv
// Oldest-ready selector: grants the ready entry with the smallest age stamp,
// lowest index on ties.
module rs_age_arbiter #(
    parameter int NUM_RS = 2,
    parameter int AGE_W  = 4
) (
    input  logic [NUM_RS-1:0]       ready,
    input  logic [NUM_RS*AGE_W-1:0] age,
    output logic [NUM_RS-1:0]       grant,
    output logic                    found
);

    logic [AGE_W-1:0] best_age_s;

    // Linear scan; strict less-than keeps the lower index on equal ages.
    always_comb begin
        grant      = {NUM_RS{1'b0}};
        found      = 1'b0;
        best_age_s = {AGE_W{1'b0}};
        for (int i = 0; i < NUM_RS; i++) begin
            if (ready[i] && (!found || (age[i*AGE_W +: AGE_W] < best_age_s))) begin
                grant      = {NUM_RS{1'b0}};
                grant[i]   = 1'b1;
                found      = 1'b1;
                best_age_s = age[i*AGE_W +: AGE_W];
            end else begin
                best_age_s = best_age_s;
            end
        end
    end

endmodule

// File: rtl/floating.sv
// Combinational single-precision FP core: add/sub (truncating, denormals
// flushed to zero), min/max, sign injection and move.
module floating
    import ex_fp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      aluop,
    input  logic [2:0]      mode,
    output logic [XLEN-1:0] result
);

    logic [31:0] a32_s;
    logic [31:0] b32_s;
    logic [31:0] res32_s;

    assign a32_s = a[31:0];
    assign b32_s = b[31:0];

    function automatic logic [31:0] fp_add(input logic [31:0] p_in, input logic [31:0] q_in);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic [7:0]  diff;
        logic [26:0] mx;
        logic [26:0] my;
        logic [27:0] sum;
        logic [22:0] frac_v;
        logic [9:0]  exp_v;
        int          msb;
        // x always carries the larger magnitude, so the result takes its sign.
        if (p_in[30:0] >= q_in[30:0]) begin
            x = p_in;
            y = q_in;
        end else begin
            x = q_in;
            y = p_in;
        end
        diff = x[30:23] - y[30:23];
        mx   = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
        my   = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
        my   = (diff > 8'd26) ? 27'd0 : (my >> diff);
        sum  = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        msb  = -1;
        for (int i = 0; i < 28; i++) begin
            if (sum[i]) begin
                msb = i;
            end
        end
        if (msb == 27) begin
            frac_v = 23'(sum >> 4);
            exp_v  = {2'b00, x[30:23]} + 10'd1;
        end else begin
            frac_v = 23'((sum << (26 - msb)) >> 3);
            exp_v  = {2'b00, x[30:23]} - 10'(26 - msb);
        end
        if (x[30:23] == 8'hFF) begin
            r = ((x[22:0] != 23'd0) || ((y[30:23] == 8'hFF) && (x[31] != y[31]))) ? FP_QNAN : x;
        end else if (msb < 0) begin
            r = 32'd0;
        end else if (exp_v[9] || (exp_v == 10'd0)) begin
            r = {x[31], 31'd0};
        end else if (exp_v >= 10'd255) begin
            r = {x[31], 8'hFF, 23'd0};
        end else begin
            r = {x[31], exp_v[7:0], frac_v};
        end
        return r;
    endfunction

    function automatic logic fp_lt(input logic [31:0] x, input logic [31:0] y);
        logic lt;
        if (x[31] != y[31]) begin
            lt = x[31] & ((x[30:0] | y[30:0]) != 31'd0);
        end else if (x[31] == 1'b0) begin
            lt = x[30:0] < y[30:0];
        end else begin
            lt = x[30:0] > y[30:0];
        end
        return lt;
    endfunction

    // Operation select; unsupported modes and encodings yield a quiet NaN.
    always_comb begin
        res32_s = FP_QNAN;
        if (mode != FP_MODE_S) begin
            res32_s = FP_QNAN;
        end else begin
            case (fp_op_e'(aluop))
                FP_ADD:   res32_s = fp_add(a32_s, b32_s);
                FP_SUB:   res32_s = fp_add(a32_s, {~b32_s[31], b32_s[30:0]});
                FP_MIN:   res32_s = fp_lt(a32_s, b32_s) ? a32_s : b32_s;
                FP_MAX:   res32_s = fp_lt(a32_s, b32_s) ? b32_s : a32_s;
                FP_SGNJ:  res32_s = {b32_s[31], a32_s[30:0]};
                FP_SGNJN: res32_s = {~b32_s[31], a32_s[30:0]};
                FP_SGNJX: res32_s = {a32_s[31] ^ b32_s[31], a32_s[30:0]};
                FP_MV:    res32_s = a32_s;
                default:  res32_s = FP_QNAN;
            endcase
        end
        result = XLEN'(res32_s);
    end

endmodule

// File: rtl/ex_fp_pipe.sv
// Pipelined FP execute slot: oldest-ready RS selection, LAT-stage pipe around
// the floating core, ROB valid/ready result handshake with stall and flush.
module ex_fp_pipe
    import ex_fp_pkg::*;
#(
    parameter int NUM_RS = 2,
    parameter int RS_W   = 114,
    parameter int XLEN   = 32,
    parameter int ROB_W  = 4,
    parameter int LAT    = 3,
    parameter int AGE_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RS*RS_W-1:0]  rs_entry,
    input  logic [NUM_RS-1:0]       rs_valid,
    input  logic [NUM_RS*AGE_W-1:0] rs_age,
    input  logic [NUM_RS*ROB_W-1:0] rs_rob_num,
    output logic [NUM_RS-1:0]       rs_issue,
    input  logic                    flush,
    output logic                    rob_valid,
    input  logic                    rob_ready,
    output logic [ROB_W-1:0]        rob_num,
    output logic [XLEN+5:0]         executed_inst,
    output logic [XLEN-1:0]         writedata_fp,
    output logic [4:0]              writeaddr_fp,
    output logic                    writeen_fp
);

    localparam int STAGE_W = stage_w(XLEN, ROB_W);

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [4:0]       op;
        wb_ctl_t          wb;
        logic [ROB_W-1:0] tag;
        logic             v;
    } s1_t;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        wb_ctl_t          wb;
        logic [ROB_W-1:0] tag;
        logic             v;
    } sn_t;

    logic [NUM_RS-1:0] ready_s;
    logic [NUM_RS-1:0] grant_s;
    logic              found_s;
    logic [RS_W-1:0]   sel_entry_s;
    logic [ROB_W-1:0]  sel_tag_s;
    logic              stall_s;
    logic              issue_ok_s;
    s1_t               s1_next_s;
    s1_t               s1_r;
    logic [XLEN-1:0]   float_res_s;
    sn_t               head_s;
    sn_t               out_s;
    logic [STAGE_W-1:0] pipe_q [1:LAT];
    logic              unused_bits_s;

    for (genvar i = 0; i < NUM_RS; i++) begin : g_ready
        assign ready_s[i] = rs_valid[i] & rs_entry[i*RS_W + SRC1_RDY] & rs_entry[i*RS_W + SRC2_RDY];
    end

    rs_age_arbiter #(
        .NUM_RS (NUM_RS),
        .AGE_W  (AGE_W)
    ) u_arb (
        .ready (ready_s),
        .age   (rs_age),
        .grant (grant_s),
        .found (found_s)
    );

    // One-hot AND-OR mux of the granted entry and its ROB tag.
    always_comb begin
        sel_entry_s = {RS_W{1'b0}};
        sel_tag_s   = {ROB_W{1'b0}};
        for (int i = 0; i < NUM_RS; i++) begin
            sel_entry_s = sel_entry_s | ({RS_W{grant_s[i]}} & rs_entry[i*RS_W +: RS_W]);
            sel_tag_s   = sel_tag_s | ({ROB_W{grant_s[i]}} & rs_rob_num[i*ROB_W +: ROB_W]);
        end
    end

    assign stall_s    = out_s.v & ~rob_ready;
    assign issue_ok_s = found_s & ~stall_s & ~flush & rst_n;
    assign rs_issue   = issue_ok_s ? grant_s : {NUM_RS{1'b0}};

    // Unpack the granted entry into the stage-1 payload.
    always_comb begin
        s1_next_s             = '0;
        s1_next_s.a           = XLEN'(sel_entry_s[SRC1_MSB:SRC1_LSB]);
        s1_next_s.b           = XLEN'(sel_entry_s[SRC2_MSB:SRC2_LSB]);
        s1_next_s.op          = sel_entry_s[OP_MSB:OP_LSB];
        s1_next_s.wb.rd       = sel_entry_s[RD_MSB:RD_LSB];
        s1_next_s.wb.regwrite = sel_entry_s[REGWR];
        s1_next_s.tag         = sel_tag_s;
        s1_next_s.v           = issue_ok_s;
    end

    assign unused_bits_s = ^{sel_entry_s[RS_W-1:OP_MSB+1], sel_entry_s[OP_LSB-1:REGWR+1],
                             sel_entry_s[SRC1_RDY], sel_entry_s[SRC2_RDY]};

    // Stage-1 operand register: flush kills, stall holds, otherwise load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r <= '0;
        end else if (flush) begin
            s1_r.v <= 1'b0;
        end else if (!stall_s) begin
            s1_r <= s1_next_s;
        end
    end

    floating #(
        .XLEN (XLEN)
    ) u_floating (
        .a      (s1_r.a),
        .b      (s1_r.b),
        .aluop  (s1_r.op),
        .mode   (FP_MODE_S),
        .result (float_res_s)
    );

    // Stage-1 operands become a result payload once evaluated.
    always_comb begin
        head_s        = '0;
        head_s.result = float_res_s;
        head_s.wb     = s1_r.wb;
        head_s.tag    = s1_r.tag;
        head_s.v      = s1_r.v;
    end

    assign pipe_q[1] = head_s;

    // Result stages 2..LAT; for LAT=1 none exist and the head is the output.
    for (genvar k = 2; k <= LAT; k++) begin : g_stage
        logic [STAGE_W-1:0] q_r;

        // Result stage register with the same flush/stall priority as stage 1.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q_r <= '0;
            end else if (flush) begin
                q_r[STAGE_V_BIT] <= 1'b0;
            end else if (!stall_s) begin
                q_r <= pipe_q[k-1];
            end
        end

        assign pipe_q[k] = q_r;
    end

    assign out_s = pipe_q[LAT];

    // A flush also withdraws the presented result so the ROB cannot take it.
    assign rob_valid     = out_s.v & ~flush;
    assign rob_num       = out_s.tag;
    assign executed_inst = {out_s.result, out_s.wb.rd, out_s.wb.regwrite};
    assign writedata_fp  = out_s.result;
    assign writeaddr_fp  = out_s.wb.rd;
    assign writeen_fp    = rob_valid & rob_ready & out_s.wb.regwrite;

endmodule
